// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron core.
// Consumes the unsigned synaptic sum from the upstream adder tree. On every
// timestep strobe (en) it leaks, integrates with saturation, compares against
// a threshold and either fires (one-cycle spike plus optional refractory
// period) or keeps the new membrane potential. All outputs are registered.
//
// Handshake: there is no back-pressure. en=1 on a rising edge is one
// integration step; its result is visible on the outputs right after that
// edge. spike is a one-cycle pulse and is 0 on every cycle not following a
// firing step.
module lif_neuron #(
    parameter int SUM_W = 7,
    parameter int MEM_W = 8,
    parameter int REF_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [SUM_W-1:0] sum_in,
    input  logic [MEM_W-1:0] threshold,
    input  logic [2:0]       leak_shift,
    input  logic [REF_W-1:0] refrac_len,
    output logic             spike,
    output logic [MEM_W-1:0] membrane,
    output logic             refractory,
    output logic [CNT_W-1:0] spike_cnt
);

    typedef enum logic [0:0] {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [REF_W-1:0] rc_q, rc_d;
    logic [MEM_W-1:0] mem_q, mem_d;
    logic             spike_q, spike_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [MEM_W-1:0] leak;
    logic [MEM_W-1:0] v_leaked;
    logic [MEM_W:0]   v_sum;
    logic [MEM_W-1:0] v_next;
    logic             fire;

    // Datapath: leak, integrate with saturation, threshold compare.
    // A shift of 0 means "no leak" rather than "leak everything".
    always_comb begin
        leak     = (leak_shift == 3'd0) ? '0 : (mem_q >> leak_shift);
        v_leaked = mem_q - leak;
        v_sum    = {1'b0, v_leaked} + {{(MEM_W + 1 - SUM_W){1'b0}}, sum_in};
        v_next   = v_sum[MEM_W] ? {MEM_W{1'b1}} : v_sum[MEM_W-1:0];
        fire     = (v_next >= threshold);
    end

    // Next-state and next-output logic; everything holds unless en is high.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        mem_d   = mem_q;
        spike_d = 1'b0;
        cnt_d   = cnt_q;
        if (en) begin
            case (state_q)
                INTEG: begin
                    if (fire) begin
                        spike_d = 1'b1;
                        mem_d   = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (refrac_len != '0) begin
                            state_d = REFRAC;
                            rc_d    = refrac_len;
                        end
                    end else begin
                        mem_d = v_next;
                    end
                end
                REFRAC: begin
                    // Input is ignored; membrane stays clamped at rest.
                    mem_d = '0;
                    if (rc_q <= REF_W'(1)) begin
                        rc_d    = '0;
                        state_d = INTEG;
                    end else begin
                        rc_d = rc_q - REF_W'(1);
                    end
                end
                default: begin
                    state_d = INTEG;
                    rc_d    = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INTEG;
            rc_q    <= '0;
            mem_q   <= '0;
            spike_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            mem_q   <= mem_d;
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
        end
    end

    assign spike      = spike_q;
    assign membrane   = mem_q;
    assign refractory = (state_q == REFRAC);
    assign spike_cnt  = cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: directed vectors with hand-computed expectations.
// Each vector {spike, membrane, refractory, spike_cnt} is queued by the driver
// and checked by an independent monitor one step after the clock edge.
module tb_lif_neuron;

    localparam int SUM_W = 7;
    localparam int MEM_W = 8;
    localparam int REF_W = 4;
    localparam int CNT_W = 8;
    localparam int W     = 1 + MEM_W + 1 + CNT_W;

    // clock / reset block
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [SUM_W-1:0] sum_in = '0;
    logic [MEM_W-1:0] threshold = '0;
    logic [2:0]       leak_shift = '0;
    logic [REF_W-1:0] refrac_len = '0;
    logic             spike;
    logic [MEM_W-1:0] membrane;
    logic             refractory;
    logic [CNT_W-1:0] spike_cnt;

    always #5 clk = ~clk;

    lif_neuron #(
        .SUM_W(SUM_W), .MEM_W(MEM_W), .REF_W(REF_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .sum_in(sum_in),
        .threshold(threshold),
        .leak_shift(leak_shift),
        .refrac_len(refrac_len),
        .spike(spike),
        .membrane(membrane),
        .refractory(refractory),
        .spike_cnt(spike_cnt)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           vectors = 0;
    int           miscompares = 0;

    // driver: apply one cycle of inputs and queue the expected result
    task automatic drive(input string nm, input logic rst, input logic e,
                         input int s, input int thr, input int ls, input int rl,
                         input logic x_spk, input int x_mem, input logic x_ref,
                         input int x_cnt);
        @(negedge clk);
        reset      = rst;
        en         = e;
        sum_in     = SUM_W'(s);
        threshold  = MEM_W'(thr);
        leak_shift = 3'(ls);
        refrac_len = REF_W'(rl);
        exp_q.push_back({x_spk, MEM_W'(x_mem), x_ref, CNT_W'(x_cnt)});
        name_q.push_back(nm);
    endtask

    // idle cycles: en low, outputs must hold with spike low
    task automatic idle(input string nm, input int n, input int x_mem,
                        input logic x_ref, input int x_cnt);
        for (int i = 0; i < n; i++)
            drive(nm, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, x_mem, x_ref, x_cnt);
    endtask

    // monitor: one output sample per clock, checked against the queue head
    always @(posedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        nm;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {spike, membrane, refractory, spike_cnt};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s: got spike=%0b mem=%0d ref=%0b cnt=%0d, want spike=%0b mem=%0d ref=%0b cnt=%0d",
                         nm, act_v[W-1], act_v[W-2 -: MEM_W], act_v[CNT_W], act_v[CNT_W-1:0],
                         exp_v[W-1], exp_v[W-2 -: MEM_W], exp_v[CNT_W], exp_v[CNT_W-1:0]);
            end
        end
    end

    // stimulus
    initial begin
        int cnt;

        // reset held for 2 cycles with en and a large input
        drive("reset0", 1, 1, 127, 100, 0, 0, 0, 0, 0, 0);
        drive("reset1", 1, 1, 127, 100, 0, 0, 0, 0, 0, 0);
        idle("post_reset", 1, 0, 0, 0);

        // no-leak integrate and fire, twice
        for (int r = 0; r < 2; r++) begin
            drive("int30", 0, 1, 30, 100, 0, 0, 0, 30, 0, r);
            drive("int60", 0, 1, 30, 100, 0, 0, 0, 60, 0, r);
            drive("int90", 0, 1, 30, 100, 0, 0, 0, 90, 0, r);
            drive("fire120", 0, 1, 30, 100, 0, 0, 1, 0, 0, r + 1);
        end
        idle("after_fire", 1, 0, 0, 2);

        // leak with shift 2
        drive("leak40", 0, 1, 40, 200, 2, 0, 0, 40, 0, 2);
        drive("leak70", 0, 1, 40, 200, 2, 0, 0, 70, 0, 2);
        drive("leak93", 0, 1, 40, 200, 2, 0, 0, 93, 0, 2);
        drive("leak110", 0, 1, 40, 200, 2, 0, 0, 110, 0, 2);
        idle("leak_hold", 5, 110, 0, 2);

        // saturation from rest
        drive("sat_rst", 1, 0, 0, 255, 0, 0, 0, 0, 0, 0);
        drive("sat127", 0, 1, 127, 255, 0, 0, 0, 127, 0, 0);
        drive("sat254", 0, 1, 127, 255, 0, 0, 0, 254, 0, 0);
        drive("sat255_fire", 0, 1, 127, 255, 0, 0, 1, 0, 0, 1);
        idle("sat_after", 1, 0, 0, 1);

        // refractory, en every 3rd cycle
        drive("ref_s1_fire", 0, 1, 20, 10, 0, 2, 1, 0, 1, 2);
        idle("ref_gap1", 2, 0, 1, 2);
        drive("ref_s2", 0, 1, 20, 10, 0, 2, 0, 0, 1, 2);
        idle("ref_gap2", 2, 0, 1, 2);
        drive("ref_s3_exit", 0, 1, 20, 10, 0, 2, 0, 0, 0, 2);
        idle("ref_gap3", 2, 0, 0, 2);
        drive("ref_s4_fire", 0, 1, 20, 10, 0, 2, 1, 0, 1, 3);
        idle("ref_gap4", 2, 0, 1, 3);
        drive("ref_s5", 0, 1, 20, 10, 0, 2, 0, 0, 1, 3);
        idle("ref_gap5", 2, 0, 1, 3);
        drive("ref_s6_exit", 0, 1, 20, 10, 0, 2, 0, 0, 0, 3);
        idle("ref_gap6", 2, 0, 0, 3);
        drive("ref_s7_fire", 0, 1, 20, 10, 0, 2, 1, 0, 1, 4);

        // reset in the middle of refractory, then a normal step
        drive("mid_ref_reset", 1, 0, 0, 10, 0, 2, 0, 0, 0, 0);
        drive("post_ref_reset", 0, 1, 30, 100, 0, 0, 0, 30, 0, 0);

        // spike counter wrap with threshold 0
        drive("wrap_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            cnt = (i + 1) % 256;
            drive("wrap_fire", 0, 1, 0, 0, 0, 0, 1, 0, 0, cnt);
        end
        idle("wrap_end", 1, 0, 0, 0);

        // drain the scoreboard with a bounded wait
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
